// File: rtl/tetris_pkg.sv
// Shared tetris definitions: board geometry defaults, offset type, op encoding
// and the placer state enum.
package tetris_pkg;

    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 20;
    localparam int DEF_ADDR_W  = 8;

    typedef logic signed [4:0] offset_t;

    typedef enum logic {
        OP_CHECK  = 1'b0,
        OP_COMMIT = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_READ,
        ST_EVAL,
        ST_WRITE,
        ST_RESP
    } placer_state_e;

endpackage

// File: rtl/tetron_placer_if.sv
// Request/response and playfield-memory signals of the tetron placer.
// master = game control + playfield RAM side, slave = placer.
interface tetron_placer_if
    import tetris_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [4:0]        anchor_row;
    logic [4:0]        anchor_col;
    offset_t           blk1_voffset;
    offset_t           blk1_hoffset;
    offset_t           blk2_voffset;
    offset_t           blk2_hoffset;
    offset_t           blk3_voffset;
    offset_t           blk3_hoffset;
    offset_t           blk4_voffset;
    offset_t           blk4_hoffset;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;
    logic              rsp_valid;
    logic              rsp_collide;
    logic              rsp_oob;

    modport master (
        output req_valid, req_op, anchor_row, anchor_col,
               blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset,
               blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset,
               rd_data,
        input  req_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data,
               rsp_valid, rsp_collide, rsp_oob
    );

    modport slave (
        input  req_valid, req_op, anchor_row, anchor_col,
               blk1_voffset, blk1_hoffset, blk2_voffset, blk2_hoffset,
               blk3_voffset, blk3_hoffset, blk4_voffset, blk4_hoffset,
               rd_data,
        output req_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data,
               rsp_valid, rsp_collide, rsp_oob
    );

endinterface

// File: rtl/tetron_cell_calc.sv
// Combinational cell position: anchor + offset -> bounds flags and playfield address.
// Optional TETRON_PLACER_SPAWN_EN: rows above the board with a legal column are spawn cells.
module tetron_cell_calc
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic [4:0]        anchor_row,
    input  logic [4:0]        anchor_col,
    input  offset_t           voffset,
    input  offset_t           hoffset,
    output logic              oob,
    output logic              spawn,
    output logic [ADDR_W-1:0] addr
);
    logic signed [5:0] row;
    logic signed [5:0] col;
    logic              col_ok;
    logic              row_low_ok;

    always_comb begin
        row        = signed'({1'b0, anchor_row}) + signed'({voffset[4], voffset});
        col        = signed'({1'b0, anchor_col}) + signed'({hoffset[4], hoffset});
        col_ok     = !col[5] && (int'(col) < BOARD_W);
        row_low_ok = row[5] || (int'(row) < BOARD_H);
`ifdef TETRON_PLACER_SPAWN_EN
        spawn = row[5] && col_ok;
        oob   = !col_ok || !row_low_ok;
`else
        spawn = 1'b0;
        oob   = row[5] || !row_low_ok || !col_ok;
`endif
        // Only meaningful for in-range cells; truncation of the rest is harmless.
        addr = ADDR_W'(int'(row) * BOARD_W + int'(col));
    end

endmodule

// File: rtl/tetron_placer.sv
// Walks four tetromino cells against the playfield RAM: CHECK reports collide/oob,
// COMMIT additionally writes a clean piece. Optional macro: TETRON_PLACER_SPAWN_EN.
module tetron_placer
    import tetris_pkg::*;
#(
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic            clk,
    input  logic            reset,
    tetron_placer_if.slave  bus
);
    placer_state_e state_reg, state_next;
    logic [1:0]    idx_reg, idx_next, idx_inc;

    op_e           op_reg;
    logic [4:0]    anchor_row_reg, anchor_col_reg;
    offset_t       voff_reg [4];
    offset_t       hoff_reg [4];

    logic [3:0]        calc_oob, calc_spawn;
    logic [ADDR_W-1:0] calc_addr [4];
    logic [ADDR_W-1:0] addr_reg  [4];
    logic [3:0]        skip_reg, spawn_reg;
    logic              oob_any_reg;
    logic              collide_reg, collide_now, rd_pend_reg;
    logic              accept;

    logic              req_ready_reg, req_ready_next;
    logic              rd_en_reg, rd_en_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_collide_reg, rsp_collide_next;
    logic              rsp_oob_reg, rsp_oob_next;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cell
            tetron_cell_calc #(
                .BOARD_W (BOARD_W),
                .BOARD_H (BOARD_H),
                .ADDR_W  (ADDR_W)
            ) u_cell (
                .anchor_row (anchor_row_reg),
                .anchor_col (anchor_col_reg),
                .voffset    (voff_reg[gi]),
                .hoffset    (hoff_reg[gi]),
                .oob        (calc_oob[gi]),
                .spawn      (calc_spawn[gi]),
                .addr       (calc_addr[gi])
            );
        end
    endgenerate

    assign accept      = bus.req_valid && req_ready_reg;
    assign idx_inc     = idx_reg + 2'd1;
    // Read data lags rd_en by one cycle; rd_pend_reg marks the cycle it is valid.
    assign collide_now = collide_reg | (rd_pend_reg & bus.rd_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_CALC;
            ST_CALC: begin
                state_next = ST_READ;
                idx_next   = 2'd0;
            end
            ST_READ: begin
                if (idx_reg == 2'd3) state_next = ST_EVAL;
                else                 idx_next   = idx_inc;
            end
            ST_EVAL: begin
                if (op_reg == OP_COMMIT && !collide_now && !oob_any_reg) begin
                    state_next = ST_WRITE;
                    idx_next   = 2'd0;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_WRITE: begin
                if (idx_reg == 2'd3) state_next = ST_RESP;
                else                 idx_next   = idx_inc;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, looking one slot ahead.
    always_comb begin
        req_ready_next   = (state_next == ST_IDLE);
        rd_en_next       = 1'b0;
        rd_addr_next     = rd_addr_reg;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr_reg;
        rsp_valid_next   = 1'b0;
        rsp_collide_next = rsp_collide_reg;
        rsp_oob_next     = rsp_oob_reg;
        case (state_reg)
            ST_CALC: begin
                rd_en_next   = !(calc_oob[0] | calc_spawn[0]);
                rd_addr_next = calc_addr[0];
            end
            ST_READ: begin
                if (idx_reg != 2'd3) begin
                    rd_en_next   = !skip_reg[idx_inc];
                    rd_addr_next = addr_reg[idx_inc];
                end
            end
            ST_EVAL: begin
                if (state_next == ST_WRITE) begin
                    wr_en_next   = !spawn_reg[0];
                    wr_addr_next = addr_reg[0];
                end else begin
                    rsp_valid_next   = 1'b1;
                    rsp_collide_next = collide_now;
                    rsp_oob_next     = oob_any_reg;
                end
            end
            ST_WRITE: begin
                if (idx_reg != 2'd3) begin
                    wr_en_next   = !spawn_reg[idx_inc];
                    wr_addr_next = addr_reg[idx_inc];
                end else begin
                    rsp_valid_next   = 1'b1;
                    rsp_collide_next = 1'b0;
                    rsp_oob_next     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready_reg   <= 1'b0;
            rd_en_reg       <= 1'b0;
            rd_addr_reg     <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_collide_reg <= 1'b0;
            rsp_oob_reg     <= 1'b0;
        end else begin
            req_ready_reg   <= req_ready_next;
            rd_en_reg       <= rd_en_next;
            rd_addr_reg     <= rd_addr_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_collide_reg <= rsp_collide_next;
            rsp_oob_reg     <= rsp_oob_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_reg <= 1'b0;
            collide_reg <= 1'b0;
        end else begin
            rd_pend_reg <= rd_en_reg;
            collide_reg <= accept ? 1'b0 : collide_now;
            if (accept) begin
                op_reg         <= op_e'(bus.req_op);
                anchor_row_reg <= bus.anchor_row;
                anchor_col_reg <= bus.anchor_col;
                voff_reg[0]    <= bus.blk1_voffset;
                hoff_reg[0]    <= bus.blk1_hoffset;
                voff_reg[1]    <= bus.blk2_voffset;
                hoff_reg[1]    <= bus.blk2_hoffset;
                voff_reg[2]    <= bus.blk3_voffset;
                hoff_reg[2]    <= bus.blk3_hoffset;
                voff_reg[3]    <= bus.blk4_voffset;
                hoff_reg[3]    <= bus.blk4_hoffset;
            end
            if (state_reg == ST_CALC) begin
                for (int i = 0; i < 4; i++) addr_reg[i] <= calc_addr[i];
                skip_reg    <= calc_oob | calc_spawn;
                spawn_reg   <= calc_spawn;
                oob_any_reg <= |calc_oob;
            end
        end
    end

    assign bus.req_ready   = req_ready_reg;
    assign bus.rd_en       = rd_en_reg;
    assign bus.rd_addr     = rd_addr_reg;
    assign bus.wr_en       = wr_en_reg;
    assign bus.wr_addr     = wr_addr_reg;
    assign bus.wr_data     = wr_en_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_collide = rsp_collide_reg;
    assign bus.rsp_oob     = rsp_oob_reg;

endmodule

// File: doc/tetron_placer.md
# tetron_placer

Consumer of the per-block offsets produced by the tetron shapers. Takes an anchor position plus four (voffset, hoffset) pairs and walks the four cells against the playfield RAM. A CHECK request reports collision and out-of-bounds status. A COMMIT request performs the same check and, if the piece is clean, writes the four cells as occupied. It sits between the game-control FSM and the playfield memory.

## Interface
- BOARD_W, 10, playfield columns
- BOARD_H, 20, playfield rows
- ADDR_W, 8, playfield address width, must satisfy 2^ADDR_W ≥ BOARD_W*BOARD_H
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready
- req_op  in  1  0 = CHECK, 1 = COMMIT
- anchor_row  in  5  unsigned, row 0 at top, increasing downward
- anchor_col  in  5  unsigned
- blkN_voffset / blkN_hoffset (N=1..4)  in  5 each  two's-complement offsets; -1 is 5'b11111
- rd_en  out  1  playfield read strobe
- rd_addr  out  ADDR_W  playfield read address
- rd_data  in  1  occupancy bit, valid one cycle after rd_en
- wr_en  out  1  playfield write strobe
- wr_addr  out  ADDR_W  playfield write address
- wr_data  out  1  constant 1 while wr_en is high
- rsp_valid  out  1  single-cycle pulse, no backpressure
- rsp_collide  out  1  at least one in-bounds cell is already occupied
- rsp_oob  out  1  at least one cell is outside the board

## Operation
- FSM states: IDLE → CALC → READ (4 cycles, index 0..3) → EVAL → {WRITE (4 cycles) | RESP} → IDLE.
- IDLE: req_ready=1. On accept, register the op, the anchor and all offsets.
- CALC: for each block, row = anchor_row + sext(voffset) and col = anchor_col + sext(hoffset), computed at 6-bit signed width.
  - A cell is oob if row<0, row≥BOARD_H, col<0 or col≥BOARD_W.
  - addr = row*BOARD_W + col.
  - Register the addresses and the oob flags.
- READ: in cycle i, assert rd_en with addr_i, except when cell i is oob, in which case the slot is consumed but rd_en stays low. OR each returned rd_data into the collide accumulator only for reads that were actually issued.
- EVAL: absorb the last rd_data. If op=COMMIT and both collide and oob are 0, go to WRITE; otherwise go to RESP.
- WRITE: in cycle i, assert wr_en with wr_addr=addr_i.
- RESP: drive rsp_valid=1 with the final flags, then return to IDLE. The flags hold their value until the next response.
- Duplicate cell addresses within one request are neither detected nor rejected.

## Timing
- All outputs are registered.
- Reset values: req_ready=0 during reset and 1 from the first cycle after reset deasserts. rd_en, wr_en, rsp_valid, rsp_collide and rsp_oob are 0. Both addresses are 0.
- The accept edge ends cycle 0. rd_en is high in cycles 2..5 and rd_data is returned in cycles 3..6.
- CHECK, or COMMIT that is rejected: rsp_valid in cycle 7.
- Clean COMMIT: wr_en in cycles 7..10, rsp_valid in cycle 11.
- Throughput: one request per 8 cycles (CHECK) or 12 cycles (COMMIT); the earliest next accept is the cycle after rsp_valid.
- Reset mid-operation: the state returns to IDLE at the sampling edge. Strobes already driven in that cycle complete; no later strobes and no rsp_valid are produced. Cells already written are not rolled back.

## Configuration
- TETRON_PLACER_SPAWN_EN, defined: a cell with row<0 and an in-range column is treated as the hidden spawn zone.
  - It is not oob, it is not read, and it is skipped during WRITE (wr_en stays low in its slot).
  - The slot timing is unchanged.
- TETRON_PLACER_SPAWN_EN, undefined: row<0 is oob, like every other bound.

## Structure
- Shared package tetris_pkg holds:
  - the BOARD_W, BOARD_H and ADDR_W defaults
  - the 5-bit signed offset type
  - the op encoding (OP_CHECK=0, OP_COMMIT=1)
  - the placer state enum
- One sub-module, tetron_cell_calc, is instantiated 4 times. It is combinational: anchor + offset → row, col, oob flag, addr.

## Test plan
- Empty board, CHECK, anchor (5,4), offsets (0,0)(0,1)(0,-1)(-1,-1) → rd_addr 54,55,53,43 in cycles 2..5; rsp_valid in cycle 7 with collide=0, oob=0.
- Same request as COMMIT → wr_addr 54,55,53,43 in cycles 7..10 with wr_data=1; rsp_valid in cycle 11 with 0/0. A subsequent CHECK of the same request returns collide=1.
- Cell 43 preloaded occupied, COMMIT of the same request → rsp_valid in cycle 7 with collide=1; no wr_en at all.
- Anchor (5,0), offsets (0,0)(0,1)(0,-1)(-1,-1) → rsp_oob=1; rd_en low in cycles 4 and 5; no writes on COMMIT.
- Anchor (0,4), offsets (0,0)(0,1)(0,-1)(-1,-1), COMMIT:
  - Macro undefined → oob=1, no writes.
  - Macro defined → oob=0; writes to 4, 5 and 3 only; rsp_valid in cycle 11.
- Clean COMMIT with reset asserted in cycle 8 → only 54 and 55 are written; no rsp_valid; req_ready=1 in the cycle after reset deasserts.
